// File: rtl/mips_dmem_responder_if.sv
// Request/response bus between a MIPS load/store unit (master) and the
// data-memory responder (slave).
interface mips_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/mips_dmem_responder.sv
// Word-addressed data memory answering one LW/SW at a time with WAIT_CYCLES wait states.
// Optional macro DMEM_RANGE_CHECK_EN: flag out-of-range addresses instead of wrapping them.
module mips_dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input logic             clk1,
    input logic             reset,
    mips_dmem_responder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_RANGE_CHECK_EN
    localparam int LW = 32;
`else
    localparam int LW = AW;
`endif
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [3:0]    cnt_r;
    logic          we_r;
    logic [LW-1:0] addr_r;
    logic [31:0]   wdata_r;
    logic          rsp_valid_r;
    logic [31:0]   rdata_r;
    logic          err_r;
    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] idx_s;
    logic          oor_s;
    logic          accept_s;

    assign accept_s = (state_r == ST_IDLE) && bus.req_valid;
    assign idx_s    = addr_r[AW-1:0];

`ifdef DMEM_RANGE_CHECK_EN
    assign oor_s       = (addr_r >= 32'(DEPTH));
    assign bus.rsp_err = err_r;
`else
    // Without range checking the address simply wraps onto the low bits.
    assign oor_s       = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = (state_r == ST_IDLE);
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rdata_r;

    // Next-state decode of the request/response sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (WAIT_LOAD != 4'd0) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, wait counter, latched request and registered response.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= 32'd0;
            rsp_valid_r <= 1'b0;
            rdata_r     <= 32'd0;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r   <= WAIT_LOAD;
                        we_r    <= bus.req_we;
                        addr_r  <= bus.req_addr[LW-1:0];
                        wdata_r <= bus.req_wdata;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    rsp_valid_r <= 1'b1;
                    err_r       <= oor_s;
                    // Stores and rejected accesses answer with zero data.
                    if (we_r || oor_s) begin
                        rdata_r <= 32'd0;
                    end else begin
                        rdata_r <= mem_r[idx_s];
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; deliberately untouched by reset so contents survive it.
    always_ff @(posedge clk1) begin
        if ((state_r == ST_ACCESS) && we_r && !oor_s && !reset) begin
            mem_r[idx_s] <= wdata_r;
        end
    end
endmodule
